// File: rtl/rv32_pkg.sv
// Shared definitions for the register-file write-back path: register/data
// widths, the write-back source select and the arbiter state encoding.
package rv32_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int XLEN       = 32;
  localparam int WB_ENTRY_W = REG_ADDR_W + XLEN;

  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

  // Which writer owns the register file port in the current cycle.
  typedef enum logic [1:0] {
    WB_NONE,
    WB_PIPE,
    WB_MD
  } wb_src_e;

  // Arbiter states: IDLE = nothing buffered, WAIT = M result(s) buffered,
  // FORCE = one-cycle forced grant of the buffered head over the pipeline.
  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_WAIT,
    ARB_FORCE
  } arb_state_e;

  // x0 is hard-wired to zero; writes to it are discarded everywhere.
  function automatic logic is_zero_reg(input logic [REG_ADDR_W-1:0] addr);
    return addr == REG_ZERO;
  endfunction

endpackage

// File: rtl/rf_wb_fifo.sv
// Small first-word-fall-through FIFO holding M-unit results {addr, data}.
// The head is visible combinationally so the arbiter can grant it in the
// same cycle it decides. Push and pop in the same cycle leave the count
// unchanged. DEPTH must be a power of two so the pointers wrap naturally.
module rf_wb_fifo
  import rv32_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int WIDTH = WB_ENTRY_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             full,
  output logic             empty,
  output logic             last
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE_CNT  = (AW+1)'(1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;

  assign head_data = mem_q[rd_ptr_q];
  assign full      = (count_q == FULL_CNT);
  assign empty     = (count_q == '0);
  assign last      = (count_q == ONE_CNT);

  // Storage array: no reset needed, entries are only read once written.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Register-file write-port arbiter between the pipeline WB stage and the
// M-extension unit. M results are buffered in rf_wb_fifo; the pipeline wins
// by default, and a buffered head that keeps losing is eventually forced
// through for one cycle while the pipeline is held. A per-register busy
// scoreboard flags RAW/WAW hazards against in-flight M results to ID.
// Optional build macro RF_WB_ARB_PERF_EN adds saturating perf counters.
module rf_wb_arbiter
  import rv32_pkg::*;
#(
  parameter int BUF_DEPTH    = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pipe_we,
  input  logic [REG_ADDR_W-1:0] pipe_waddr,
  input  logic [XLEN-1:0]       pipe_wd,
  output logic                  pipe_hold,
  input  logic                  md_issue,
  input  logic [REG_ADDR_W-1:0] md_issue_rd,
  input  logic                  md_valid,
  input  logic [REG_ADDR_W-1:0] md_waddr,
  input  logic [XLEN-1:0]       md_wd,
  output logic                  md_ready,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic [REG_ADDR_W-1:0] id_rd,
  output logic                  id_stall,
  output logic                  rf_we,
  output logic [REG_ADDR_W-1:0] rf_waddr,
  output logic [XLEN-1:0]       rf_wd
`ifdef RF_WB_ARB_PERF_EN
  ,
  output logic [31:0]           perf_collisions,
  output logic [31:0]           perf_stalls
`endif
);

  localparam int CNT_W = (STARVE_LIMIT > 1) ? $clog2(STARVE_LIMIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STARVE_LIMIT - 1);

  // ---------------------------------------------------------------
  // M-result buffer
  // ---------------------------------------------------------------
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  fifo_last;
  logic [WB_ENTRY_W-1:0] fifo_head;
  logic [REG_ADDR_W-1:0] head_addr;
  logic [XLEN-1:0]       head_data;
  logic                  push;
  logic                  pop;

  assign head_addr = fifo_head[XLEN +: REG_ADDR_W];
  assign head_data = fifo_head[XLEN-1:0];

  // Held low during reset so the M unit never hands over a result that the
  // reset would discard.
  assign md_ready = rst & ~fifo_full;
  assign push     = md_valid & md_ready;

  rf_wb_fifo #(
    .DEPTH (BUF_DEPTH),
    .WIDTH (WB_ENTRY_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data ({md_waddr, md_wd}),
    .pop       (pop),
    .head_data (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .last      (fifo_last)
  );

  // ---------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------
  arb_state_e       state_q;
  arb_state_e       state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  wb_src_e          wb_src;
  logic             pipe_req;
  logic             head_lost;
  logic             fifo_drains;

  // A pipeline write to x0 is not a real request and never blocks the FIFO.
  assign pipe_req    = pipe_we & ~is_zero_reg(pipe_waddr);
  assign pop         = (wb_src == WB_MD);
  assign head_lost   = (wb_src == WB_PIPE) & ~fifo_empty;
  assign fifo_drains = pop & ~push & fifo_last;

  // Decoded from the state register only: no path from pipe_we to pipe_hold.
  assign pipe_hold = (state_q == ARB_FORCE);

  // Pick the port owner: forced head, then pipeline, then buffered head.
  always_comb begin
    wb_src = WB_NONE;
    if (state_q == ARB_FORCE) begin
      wb_src = WB_MD;
    end else if (pipe_req) begin
      wb_src = WB_PIPE;
    end else if (!fifo_empty) begin
      wb_src = WB_MD;
    end
  end

  // Starvation FSM next-state: count consecutive losses of the head.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ARB_IDLE: begin
        cnt_d = '0;
        if (push) begin
          state_d = ARB_WAIT;
        end
      end
      ARB_WAIT: begin
        if (pop) begin
          cnt_d = '0;
          if (fifo_drains) begin
            state_d = ARB_IDLE;
          end
        end else if (head_lost) begin
          if (cnt_q == CNT_LAST) begin
            state_d = ARB_FORCE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      ARB_FORCE: begin
        cnt_d   = '0;
        state_d = fifo_drains ? ARB_IDLE : ARB_WAIT;
      end
      default: begin
        state_d = ARB_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Starvation FSM state register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ARB_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // ---------------------------------------------------------------
  // Register file write port
  // ---------------------------------------------------------------
  logic                  rf_we_q;
  logic                  rf_we_d;
  logic [REG_ADDR_W-1:0] rf_waddr_q;
  logic [REG_ADDR_W-1:0] rf_waddr_d;
  logic [XLEN-1:0]       rf_wd_q;
  logic [XLEN-1:0]       rf_wd_d;

  assign rf_we    = rf_we_q;
  assign rf_waddr = rf_waddr_q;
  assign rf_wd    = rf_wd_q;

  // Select write data from the granted source; x0 results pop silently and
  // address/data hold their last value whenever no write is issued.
  always_comb begin
    rf_we_d    = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wd_d    = rf_wd_q;
    case (wb_src)
      WB_PIPE: begin
        rf_we_d    = 1'b1;
        rf_waddr_d = pipe_waddr;
        rf_wd_d    = pipe_wd;
      end
      WB_MD: begin
        if (!is_zero_reg(head_addr)) begin
          rf_we_d    = 1'b1;
          rf_waddr_d = head_addr;
          rf_wd_d    = head_data;
        end
      end
      default: begin
        rf_we_d = 1'b0;
      end
    endcase
  end

  // Registered write port.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wd_q    <= '0;
    end else begin
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wd_q    <= rf_wd_d;
    end
  end

  // ---------------------------------------------------------------
  // Busy scoreboard
  // ---------------------------------------------------------------
  logic [31:0] busy_q;
  logic [31:0] busy_d;

  // Per-register next state: a new issue wins over the clear from a pop of
  // the same address, so the younger in-flight op stays tracked.
  genvar gi;
  for (gi = 0; gi < 32; gi++) begin : g_busy
    if (gi == 0) begin : g_zero
      assign busy_d[gi] = 1'b0;
    end else begin : g_reg
      logic set_hit;
      logic clr_hit;
      assign set_hit    = md_issue & (md_issue_rd == REG_ADDR_W'(gi));
      assign clr_hit    = pop & (head_addr == REG_ADDR_W'(gi));
      assign busy_d[gi] = set_hit | (busy_q[gi] & ~clr_hit);
    end
  end

  // Scoreboard register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign id_stall = (~is_zero_reg(id_rs1) & busy_q[id_rs1]) |
                    (~is_zero_reg(id_rs2) & busy_q[id_rs2]) |
                    (~is_zero_reg(id_rd)  & busy_q[id_rd]);

`ifdef RF_WB_ARB_PERF_EN
  // ---------------------------------------------------------------
  // Performance counters (saturating)
  // ---------------------------------------------------------------
  logic [31:0] perf_coll_q;
  logic [31:0] perf_stall_q;

  assign perf_collisions = perf_coll_q;
  assign perf_stalls     = perf_stall_q;

  // Count pipeline/FIFO contention cycles and ID stall cycles.
  always_ff @(posedge clk) begin
    if (!rst) begin
      perf_coll_q  <= '0;
      perf_stall_q <= '0;
    end else begin
      if (pipe_we && !fifo_empty && (perf_coll_q != 32'hFFFF_FFFF)) begin
        perf_coll_q <= perf_coll_q + 32'd1;
      end
      if (id_stall && (perf_stall_q != 32'hFFFF_FFFF)) begin
        perf_stall_q <= perf_stall_q + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Self-checking bench for rf_wb_arbiter: a directed vector table, hand
// sequences for starvation / ordering / scoreboard / reset corners, and a
// randomized phase checked against a queue-based reference model.
module tb_rf_wb_arbiter;

  localparam int BUF_DEPTH    = 2;
  localparam int STARVE_LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        pipe_we;
  logic [4:0]  pipe_waddr;
  logic [31:0] pipe_wd;
  logic        pipe_hold;
  logic        md_issue;
  logic [4:0]  md_issue_rd;
  logic        md_valid;
  logic [4:0]  md_waddr;
  logic [31:0] md_wd;
  logic        md_ready;
  logic [4:0]  id_rs1;
  logic [4:0]  id_rs2;
  logic [4:0]  id_rd;
  logic        id_stall;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wd;
`ifdef RF_WB_ARB_PERF_EN
  logic [31:0] perf_collisions;
  logic [31:0] perf_stalls;
`endif

  always #5 clk = ~clk;

  rf_wb_arbiter #(
    .BUF_DEPTH    (BUF_DEPTH),
    .STARVE_LIMIT (STARVE_LIMIT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .pipe_we     (pipe_we),
    .pipe_waddr  (pipe_waddr),
    .pipe_wd     (pipe_wd),
    .pipe_hold   (pipe_hold),
    .md_issue    (md_issue),
    .md_issue_rd (md_issue_rd),
    .md_valid    (md_valid),
    .md_waddr    (md_waddr),
    .md_wd       (md_wd),
    .md_ready    (md_ready),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_rd       (id_rd),
    .id_stall    (id_stall),
    .rf_we       (rf_we),
    .rf_waddr    (rf_waddr),
    .rf_wd       (rf_wd)
`ifdef RF_WB_ARB_PERF_EN
    ,
    .perf_collisions (perf_collisions),
    .perf_stalls     (perf_stalls)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
  } mentry_t;

  mentry_t     mq[$];
  bit [31:0]   m_busy;
  int          m_lose;
  bit          m_force;
  logic        exp_we;
  logic [4:0]  exp_waddr;
  logic [31:0] exp_wd;

  // Apply one clock edge of the rules to the model using the current inputs.
  task automatic model_update();
    mentry_t h;
    bit had, pipe_ok, can_push, do_pop, lost, next_force;
    if (!rst) begin
      mq.delete();
      m_busy = '0; m_lose = 0; m_force = 0;
      exp_we = 0; exp_waddr = '0; exp_wd = '0;
      return;
    end
    had      = mq.size() > 0;
    can_push = mq.size() < BUF_DEPTH;
    pipe_ok  = pipe_we && (pipe_waddr != 0);
    do_pop = 0; lost = 0; next_force = 0;
    exp_we = 0;
    if (m_force) do_pop = 1;
    else if (pipe_ok) begin
      exp_we = 1; exp_waddr = pipe_waddr; exp_wd = pipe_wd;
      lost = had;
    end else if (had) do_pop = 1;
    if (do_pop) begin
      h = mq.pop_front();
      if (h.addr != 0) begin
        exp_we = 1; exp_waddr = h.addr; exp_wd = h.data;
      end
      m_busy[h.addr] = 0;
      m_lose = 0;
    end else if (lost) begin
      m_lose++;
      if (m_lose == STARVE_LIMIT) begin
        next_force = 1;
        m_lose = 0;
      end
    end
    if (md_issue && md_issue_rd != 0) m_busy[md_issue_rd] = 1;
    if (md_valid && can_push) begin
      h.addr = md_waddr; h.data = md_wd;
      mq.push_back(h);
    end
    m_force = next_force;
  endtask

  // ---------------- stepping ----------------
  bit   chk_comb;
  logic c_stall, c_ready, c_hold;

  task automatic step();
    logic e_stall;
    #1;
    c_stall = id_stall; c_ready = md_ready; c_hold = pipe_hold;
    if (chk_comb) begin
      e_stall = (id_rs1 != 0 && m_busy[id_rs1]) || (id_rs2 != 0 && m_busy[id_rs2]) ||
                (id_rd != 0 && m_busy[id_rd]);
      chk("model_md_ready", c_ready, rst && (mq.size() < BUF_DEPTH));
      chk("model_id_stall", c_stall, e_stall);
      chk("model_pipe_hold", c_hold, m_force);
    end
    model_update();
    @(posedge clk);
    #1;
    chk("model_rf_we", rf_we, exp_we);
    chk("model_rf_waddr", rf_waddr, exp_waddr);
    chk("model_rf_wd", rf_wd, exp_wd);
  endtask

  task automatic set_idle();
    rst = 1; pipe_we = 0; pipe_waddr = 0; pipe_wd = 0;
    md_issue = 0; md_issue_rd = 0; md_valid = 0; md_waddr = 0; md_wd = 0;
    id_rs1 = 0; id_rs2 = 0; id_rd = 0;
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic pw; logic [4:0] pa; logic [31:0] pd;
    logic mi; logic [4:0] mir;
    logic mv; logic [4:0] ma; logic [31:0] md;
    logic [4:0] rs1;
    logic e_stall; logic e_ready; logic e_we; logic [4:0] e_waddr; logic [31:0] e_wd;
  } vec_t;

  localparam int NV = 10;
  vec_t tbl[NV];

  mentry_t got[$];

  initial begin
    // pw pa pd        mi mir  mv ma md        rs1 | stall ready we waddr wd
    tbl[0] = '{1'b0, 5'd0, 32'h0,  1'b1, 5'd5, 1'b0, 5'd0, 32'h0,  5'd5, 1'b0, 1'b1, 1'b0, 5'd0, 32'h0};
    tbl[1] = '{1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 1'b0, 5'd0, 32'h0,  5'd5, 1'b1, 1'b1, 1'b0, 5'd0, 32'h0};
    tbl[2] = '{1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 1'b1, 5'd5, 32'h2A, 5'd5, 1'b1, 1'b1, 1'b0, 5'd0, 32'h0};
    tbl[3] = '{1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 1'b0, 5'd0, 32'h0,  5'd5, 1'b1, 1'b1, 1'b1, 5'd5, 32'h2A};
    tbl[4] = '{1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 1'b0, 5'd0, 32'h0,  5'd5, 1'b0, 1'b1, 1'b0, 5'd0, 32'h0};
    tbl[5] = '{1'b1, 5'd3, 32'h11, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0,  5'd0, 1'b0, 1'b1, 1'b1, 5'd3, 32'h11};
    tbl[6] = '{1'b1, 5'd0, 32'h55, 1'b1, 5'd0, 1'b1, 5'd0, 32'h99, 5'd0, 1'b0, 1'b1, 1'b0, 5'd0, 32'h0};
    tbl[7] = '{1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 1'b0, 5'd0, 32'h0,  5'd0, 1'b0, 1'b1, 1'b0, 5'd0, 32'h0};
    tbl[8] = '{1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 1'b1, 5'd4, 32'h44, 5'd0, 1'b0, 1'b1, 1'b0, 5'd0, 32'h0};
    tbl[9] = '{1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 1'b0, 5'd0, 32'h0,  5'd0, 1'b0, 1'b1, 1'b1, 5'd4, 32'h44};

    // Reset: first cycle has unknown pre-reset state, so only rf_* is checked.
    set_idle();
    rst = 0; chk_comb = 0;
    step();
    chk_comb = 1;
    step();
    chk("reset_md_ready_low", c_ready, 1'b0);
    chk("reset_rf_we", rf_we, 1'b0);
    chk("reset_pipe_hold", c_hold, 1'b0);
    rst = 1;

    for (int i = 0; i < NV; i++) begin
      pipe_we = tbl[i].pw; pipe_waddr = tbl[i].pa; pipe_wd = tbl[i].pd;
      md_issue = tbl[i].mi; md_issue_rd = tbl[i].mir;
      md_valid = tbl[i].mv; md_waddr = tbl[i].ma; md_wd = tbl[i].md;
      id_rs1 = tbl[i].rs1;
      step();
      $display("vec %0d: stall=%0b ready=%0b rf_we=%0b rf_waddr=%0d rf_wd=%08h",
               i, c_stall, c_ready, rf_we, rf_waddr, rf_wd);
      chk($sformatf("vec%0d_id_stall", i), c_stall, tbl[i].e_stall);
      chk($sformatf("vec%0d_md_ready", i), c_ready, tbl[i].e_ready);
      chk($sformatf("vec%0d_pipe_hold", i), c_hold, 1'b0);
      chk($sformatf("vec%0d_rf_we", i), rf_we, tbl[i].e_we);
      if (tbl[i].e_we) begin
        chk($sformatf("vec%0d_rf_waddr", i), rf_waddr, tbl[i].e_waddr);
        chk($sformatf("vec%0d_rf_wd", i), rf_wd, tbl[i].e_wd);
      end
    end
    set_idle();

    // Starvation: pipeline writes x3 every cycle, one M result for x7.
    pipe_we = 1; pipe_waddr = 5'd3; pipe_wd = 32'h11;
    md_valid = 1; md_waddr = 5'd7; md_wd = 32'h77;
    step();
    md_valid = 0;
    for (int k = 1; k <= 6; k++) begin
      step();
      $display("starve k=%0d: hold=%0b rf_we=%0b rf_waddr=%0d rf_wd=%08h", k, c_hold, rf_we, rf_waddr, rf_wd);
      chk($sformatf("starve%0d_hold", k), c_hold, (k == 5));
      chk($sformatf("starve%0d_rf_waddr", k), rf_waddr, (k == 5) ? 32'd7 : 32'd3);
      chk($sformatf("starve%0d_rf_wd", k), rf_wd, (k == 5) ? 32'h77 : 32'h11);
    end

    // Back-to-back M results under continuous pipeline writes.
    pipe_wd = 32'h33;
    md_valid = 1; md_waddr = 5'd10; md_wd = 32'hA1;
    step();
    md_waddr = 5'd11; md_wd = 32'hB2;
    step();
    chk("b2b_ready_one_entry", c_ready, 1'b1);
    md_valid = 0;
    got.delete();
    for (int i = 0; i < 30; i++) begin
      step();
      if (i == 0) chk("b2b_ready_full", c_ready, 1'b0);
      if (rf_we && rf_waddr != 5'd3) got.push_back('{rf_waddr, rf_wd});
      if (got.size() == 2) break;
    end
    $display("b2b: %0d M results written", got.size());
    chk("b2b_count", got.size(), 2);
    if (got.size() == 2) begin
      chk("b2b_first_addr", got[0].addr, 5'd10);
      chk("b2b_first_data", got[0].data, 32'hA1);
      chk("b2b_second_addr", got[1].addr, 5'd11);
      chk("b2b_second_data", got[1].data, 32'hB2);
    end
    set_idle();
    step();

    // Re-issue of rd=9 in the cycle its older result pops keeps busy[9].
    md_issue = 1; md_issue_rd = 5'd9;
    step();
    md_issue = 0; md_valid = 1; md_waddr = 5'd9; md_wd = 32'h9;
    step();
    md_valid = 0; md_issue = 1; md_issue_rd = 5'd9;
    step();
    chk("reissue_pop_write", rf_waddr, 5'd9);
    md_issue = 0; id_rs2 = 5'd9;
    md_valid = 1; md_waddr = 5'd9; md_wd = 32'h99;
    step();
    $display("reissue: id_stall=%0b", c_stall);
    chk("reissue_busy_kept", c_stall, 1'b1);
    md_valid = 0;
    step();
    step();
    chk("reissue_busy_cleared", c_stall, 1'b0);
    set_idle();

    // Reset with 2 buffered results and busy x12/x13/x14.
    pipe_we = 1; pipe_waddr = 5'd3; pipe_wd = 32'h44;
    md_issue = 1; md_issue_rd = 5'd12;
    step();
    md_issue_rd = 5'd13; md_valid = 1; md_waddr = 5'd12; md_wd = 32'hC;
    step();
    md_issue_rd = 5'd14; md_waddr = 5'd13; md_wd = 32'hD;
    step();
    md_issue = 0; md_valid = 0; id_rs1 = 5'd12; rst = 0;
    step();
    chk("rst_mid_ready_low", c_ready, 1'b0);
    chk("rst_mid_rf_we", rf_we, 1'b0);
    pipe_we = 0;
    step();
    chk("rst_mid_stall_cleared", c_stall, 1'b0);
    chk("rst_mid_ready_still_low", c_ready, 1'b0);
    rst = 1;
    step();
    $display("post-reset: ready=%0b stall=%0b rf_we=%0b", c_ready, c_stall, rf_we);
    chk("rst_release_ready", c_ready, 1'b1);
    chk("rst_release_stall", c_stall, 1'b0);
    chk("rst_release_rf_we", rf_we, 1'b0);
    set_idle();

    // Randomized traffic against the model.
    for (int i = 0; i < 800; i++) begin
      rst         = ($urandom_range(149) != 0);
      pipe_we     = ($urandom_range(9) < 6);
      pipe_waddr  = 5'($urandom_range(7));
      pipe_wd     = $urandom;
      md_issue    = ($urandom_range(3) == 0);
      md_issue_rd = 5'($urandom_range(15));
      md_valid    = ($urandom_range(2) == 0);
      md_waddr    = 5'($urandom_range(7));
      md_wd       = $urandom;
      id_rs1      = 5'($urandom_range(15));
      id_rs2      = 5'($urandom_range(15));
      id_rd       = 5'($urandom_range(15));
      step();
      if (i % 100 == 0)
        $display("rand %0d: rf_we=%0b rf_waddr=%0d rf_wd=%08h hold=%0b", i, rf_we, rf_waddr, rf_wd, c_hold);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/rf_wb_arbiter.md
Name: rf_wb_arbiter

Overview:
- Shares the register file's single write port between two writers: the in-order pipeline WB stage and the multi-cycle M-extension (MUL/DIV) unit.
- Buffers M-unit results and gives pipeline WB priority, with a starvation guard.
- Keeps a per-register busy scoreboard that stalls ID on RAW/WAW hazards against in-flight M results.
- Sits between WB, the M unit, the ID hazard logic and the register file write port.

Parameters:
- BUF_DEPTH, 2, M-result holding FIFO entries (power of 2, >=2)
- STARVE_LIMIT, 4, consecutive cycles a buffered M result may lose arbitration before forcing a grant

Ports:
- clk  in  1  clock, posedge
- rst  in  1  synchronous, active-low reset
- pipe_we  in  1  pipeline WB write request, no backpressure
- pipe_waddr  in  5  pipeline WB destination
- pipe_wd  in  32  pipeline WB data
- pipe_hold  out  1  pipeline must hold WB this cycle; pipe_we is ignored
- md_issue  in  1  M op issued this cycle
- md_issue_rd  in  5  rd of the issued M op
- md_valid  in  1  M result valid
- md_waddr  in  5  M result destination
- md_wd  in  32  M result data
- md_ready  out  1  FIFO can accept the result (!full)
- id_rs1  in  5  ID source 1
- id_rs2  in  5  ID source 2
- id_rd  in  5  ID destination
- id_stall  out  1  ID hazard against a busy register
- rf_we  out  1  register file write enable (registered)
- rf_waddr  out  5  register file write address (registered)
- rf_wd  out  32  register file write data (registered)

Behaviour:
- Reset (rst=0 at posedge): rf_we=0, rf_waddr=0, rf_wd=0, pipe_hold=0.
  - FIFO emptied, so md_ready=1 after reset; md_ready=0 during reset cycles.
  - All busy bits cleared, starve counter cleared, FSM to IDLE.
  - Reset mid-operation discards buffered results and pending busy bits.
- Scoreboard, 32 bits:
  - md_issue with md_issue_rd!=0 sets busy[rd].
  - busy[a] clears in the cycle the FIFO head for address a is granted.
  - Simultaneous set and clear on the same address: set wins.
  - busy[0] is always 0.
- id_stall, combinational: busy[id_rs1] | busy[id_rs2] | busy[id_rd], excluding x0.
- FIFO push: md_valid & md_ready. A push when full is impossible by construction.
- Arbitration each cycle, results registered to rf_* at the next posedge:
  - FORCE state: grant FIFO head; pipe_hold=1; pipe_we ignored.
  - else pipe_we & pipe_waddr!=0: grant pipeline.
  - else FIFO non-empty: grant and pop FIFO head.
  - else rf_we<=0.
- Writes to x0 from either source are dropped: rf_we<=0, no pop credit needed for pipeline; an M result to x0 is popped silently.
- Latency:
  - Pipeline: pipe_* at cycle N -> rf_* valid after posedge N+1.
  - M: push at N -> earliest pop N+1 -> rf_* at N+2.
- A same-cycle push and pop is allowed; the FIFO count is unchanged.
- FSM:
  - IDLE: FIFO empty; counter=0. Goes to WAIT when a push occurs.
  - WAIT: FIFO non-empty. Counter increments each cycle the head loses to the pipeline and resets to 0 on each pop. Goes to FORCE when counter==STARVE_LIMIT-1 and the head loses again. Goes to IDLE when the FIFO becomes empty.
  - FORCE: lasts exactly one cycle; pops the head; counter<=0. Next state is WAIT if entries remain, else IDLE.
- pipe_hold is decoded from the state register (FORCE) only, so there is no combinational path from pipe_we.

Optional Feature:
- Macro: RF_WB_ARB_PERF_EN.
- Defined: adds outputs perf_collisions[31:0] and perf_stalls[31:0].
  - perf_collisions counts cycles where pipe_we and a non-empty FIFO coexist.
  - perf_stalls counts id_stall cycles.
  - Both are reset to 0 and saturate at 0xFFFFFFFF.
- Undefined: these ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared package rv32_pkg holds:
  - REG_ADDR_W=5, XLEN=32, REG_ZERO=5'd0.
  - wb_src_e enum {WB_NONE, WB_PIPE, WB_MD}.
  - arb_state_e enum {ARB_IDLE, ARB_WAIT, ARB_FORCE}.
- One natural sub-module, rf_wb_fifo: synchronous FIFO, 37-bit entries {addr,data}, with full/empty flags and same-cycle push/pop support.

Test Plan:
- Reset, then md_issue rd=5, then id_rs1=5 -> id_stall=1. md_valid addr=5 data=0x0000002A with no pipe_we -> rf_we=1, rf_waddr=5, rf_wd=0x2A two cycles after the push; id_stall drops in the pop cycle.
- pipe_we addr=3 data=0x11 held every cycle while an M result for addr=7 is buffered, STARVE_LIMIT=4:
  - pipe_hold=1 in cycle 5 after the push.
  - rf_* then writes 7 (the M result), then pipeline writes resume.
- Two back-to-back M results with continuous pipe_we:
  - md_ready=0 when the FIFO is full.
  - Both M results are eventually written in order; none are lost.
- pipe_we addr=0 and an M result addr=0 -> rf_we stays 0; the FIFO drains; busy[0] is never set.
- md_issue rd=9 in the same cycle that the FIFO head for rd=9 pops -> busy[9] stays 1.
- rst=0 asserted with 2 buffered results and 3 busy bits -> next cycle rf_we=0, md_ready=0, id_stall=0; after release, md_ready=1.
